// File: rtl/display_scan_driver_if.sv
// Bundles the value/attribute inputs and pin-level outputs of the display scan driver.
// Latency: none, this is wiring only.
// Backpressure: none; the producer may pulse load at any time and the driver always accepts it.
interface display_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  en_i;
    logic                  load_i;
    logic [4*DIGITS-1:0]   value_i;
    logic [DIGITS-1:0]     blank_i;
    logic [DIGITS-1:0]     dp_i;
    logic [DIGITS-1:0]     blink_i;
    logic                  lz_suppress_i;
    logic [6:0]            seg_o;
    logic                  dp_o;
    logic [DIGITS-1:0]     an_o;
    logic                  frame_o;

    // Datapath side: supplies value and attributes, observes the pins.
    modport master (
        output en_i, load_i, value_i, blank_i, dp_i, blink_i, lz_suppress_i,
        input  seg_o, dp_o, an_o, frame_o
    );

    // Driver side.
    modport slave (
        input  en_i, load_i, value_i, blank_i, dp_i, blink_i, lz_suppress_i,
        output seg_o, dp_o, an_o, frame_o
    );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-coherent value/attribute capture.
// Latency: pins are registered, one cycle behind the (cnt, idx, active) scan state.
// Backpressure: none; a load is always accepted and takes effect at the next frame boundary.
module display_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int GUARD          = 2,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    display_scan_driver_if.slave  bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0]     CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLK_LAST = BW'(BLINK_FRAMES - 1);

    // XOR masks that turn active-high "lit" values into pin levels; also the off levels.
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW != 0}};

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   blank;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blink;
        logic                lz;
    } attr_t;

    logic [CW-1:0]     cnt_q;
    logic [IW-1:0]     idx_q;
    logic [BW-1:0]     blk_cnt_q;
    logic              blk_phase_q;
    attr_t             act_q;
    attr_t             pend_q;
    attr_t             cap;
    logic              pend_vld_q;

    logic              frame_end;
    logic              guard_done;
    logic [DIGITS-1:0] sup;
    logic [3:0]        nib;
    logic              dark;
    logic [6:0]        seg_lit;
    logic              dp_lit;
    logic [DIGITS-1:0] an_lit;

    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] an_q;
    logic              frame_q;

    // Glyph table, active-high {a,b,c,d,e,f,g}; F renders as "K".
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'b1111110;
            4'h1:    glyph = 7'b0110000;
            4'h2:    glyph = 7'b1101101;
            4'h3:    glyph = 7'b1111001;
            4'h4:    glyph = 7'b0110011;
            4'h5:    glyph = 7'b1011011;
            4'h6:    glyph = 7'b1011111;
            4'h7:    glyph = 7'b1110000;
            4'h8:    glyph = 7'b1111111;
            4'h9:    glyph = 7'b1111011;
            4'hA:    glyph = 7'b1110111;
            4'hB:    glyph = 7'b0011111;
            4'hC:    glyph = 7'b1001110;
            4'hD:    glyph = 7'b0111101;
            4'hE:    glyph = 7'b1001111;
            default: glyph = 7'b1010111;
        endcase
    endfunction

    assign frame_end  = bus.en_i && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    assign guard_done = 32'(cnt_q) >= 32'(GUARD);

    // Snapshot of everything a load captures.
    always_comb begin
        cap.value = bus.value_i;
        cap.blank = bus.blank_i;
        cap.dp    = bus.dp_i;
        cap.blink = bus.blink_i;
        cap.lz    = bus.lz_suppress_i;
    end

    // A digit is a leading zero when it and every more-significant nibble are zero; digit 0 never is.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        sup      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (act_q.value[4*k +: 4] == 4'h0);
            sup[k]   = act_q.lz && all_zero && (k != 0);
        end
    end

    // Active-high image of the digit currently under scan.
    always_comb begin
        nib     = act_q.value[4*int'(idx_q) +: 4];
        dark    = act_q.blank[idx_q] | sup[idx_q] | (act_q.blink[idx_q] & blk_phase_q);
        seg_lit = dark ? 7'b0 : glyph(nib);
        dp_lit  = ~dark & act_q.dp[idx_q];
        an_lit  = guard_done ? (DIGITS'(1) << idx_q) : '0;
    end

    // Slot prescaler and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (bus.en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Loads park in pending and move to active only at a frame boundary so a frame never tears.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else if (bus.load_i && frame_end) begin
            act_q      <= cap;
            pend_vld_q <= 1'b0;
        end else if (bus.load_i) begin
            pend_q     <= cap;
            pend_vld_q <= 1'b1;
        end else if (frame_end && pend_vld_q) begin
            act_q      <= pend_q;
            pend_vld_q <= 1'b0;
        end
    end

    // Blink phase toggles every BLINK_FRAMES completed frames.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
        end else if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_q   <= '0;
                blk_phase_q <= ~blk_phase_q;
            end else begin
                blk_cnt_q   <= blk_cnt_q + 1'b1;
            end
        end
    end

    // Registered pins: off while disabled, otherwise the current digit image at board polarity.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else if (!bus.en_i) begin
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_lit ^ SEG_OFF;
            dp_q    <= dp_lit ^ DP_OFF;
            an_q    <= an_lit ^ AN_OFF;
            frame_q <= frame_end;
        end
    end

    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.an_o    = an_q;
    assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: 4 digits, 4-cycle slots, 1-cycle guard, 2-frame blink.
// Latency: expectations assume pins lag the scan state by one cycle, sampled on the falling edge.
// Backpressure: not applicable; loads are pulsed at chosen slots within a frame.
module tb_display_scan_driver;

    localparam logic [6:0] G0  = 7'b1111110;
    localparam logic [6:0] G1  = 7'b0110000;
    localparam logic [6:0] G2  = 7'b1101101;
    localparam logic [6:0] G3  = 7'b1111001;
    localparam logic [6:0] G4  = 7'b0110011;
    localparam logic [6:0] G5  = 7'b1011011;
    localparam logic [6:0] G7  = 7'b1110000;
    localparam logic [6:0] GA  = 7'b1110111;
    localparam logic [6:0] GF  = 7'b1010111;
    localparam logic [6:0] OFF = 7'b0000000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    display_scan_driver_if #(.DIGITS(4)) bus ();

    display_scan_driver #(
        .DIGITS(4), .CLK_DIV(4), .GUARD(1), .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: step to the falling edge and compare all four pins (pin-level values).
    task automatic cyc(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                       input logic edp, input logic efr);
        @(negedge clk);
        chk({tag, ".an"},    32'(bus.an_o),    32'(ean));
        chk({tag, ".seg"},   32'(bus.seg_o),   32'(eseg));
        chk({tag, ".dp"},    32'(bus.dp_o),    32'(edp));
        chk({tag, ".frame"}, 32'(bus.frame_o), 32'(efr));
    endtask

    // One aligned 16-cycle frame. eseg/edp are active-high per digit; up to two load pulses.
    task automatic run_frame(input string nm, input logic [3:0][6:0] eseg, input logic [3:0] edp,
                             input int la1, input logic [15:0] lv1,
                             input int la2, input logic [15:0] lv2);
        for (int j = 0; j < 16; j++) begin
            int d;
            int c;
            logic [3:0] ean;
            d = j / 4;
            c = j % 4;
            if (j == la1) begin
                bus.value_i = lv1;
                bus.load_i  = 1'b1;
            end else if (j == la2) begin
                bus.value_i = lv2;
                bus.load_i  = 1'b1;
            end else begin
                bus.load_i  = 1'b0;
            end
            ean = (c >= 1) ? ~(4'b0001 << d) : 4'b1111;
            cyc($sformatf("%s.j%0d", nm, j), ean, ~eseg[d], ~edp[d], (j == 15));
        end
        bus.load_i = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.en_i          = 1'b0;
        bus.load_i        = 1'b0;
        bus.value_i       = '0;
        bus.blank_i       = '0;
        bus.dp_i          = '0;
        bus.blink_i       = '0;
        bus.lz_suppress_i = 1'b0;

        // Reset state: everything off.
        repeat (3) @(negedge clk);
        chk("rst.an",    32'(bus.an_o),    32'h0000000F);
        chk("rst.seg",   32'(bus.seg_o),   32'h0000007F);
        chk("rst.dp",    32'(bus.dp_o),    32'h00000001);
        chk("rst.frame", 32'(bus.frame_o), 32'h00000000);

        // Frame 1 still shows the reset value; 0x1234 loaded at slot start lands next frame.
        rst_n    = 1'b1;
        bus.en_i = 1'b1;
        run_frame("f1", {G0, G0, G0, G0}, 4'b0000, 0, 16'h1234, -1, 16'h0);
        // Frame 2 shows 1234; queue 0x0007 with leading-zero suppression.
        bus.lz_suppress_i = 1'b1;
        run_frame("f2", {G1, G2, G3, G4}, 4'b0000, 0, 16'h0007, -1, 16'h0);
        // Upper three digits suppressed; queue all-zero value.
        run_frame("f3", {OFF, OFF, OFF, G7}, 4'b0000, 0, 16'h0000, -1, 16'h0);
        // Digit 0 always shows; 0xAAAA loaded mid-frame at idx 1 must not tear this frame.
        run_frame("f4", {OFF, OFF, OFF, G0}, 4'b0000, 4, 16'hAAAA, -1, 16'h0);
        // Pending 0x3333 then a frame-end load of 0x5555 that goes straight to active.
        bus.lz_suppress_i = 1'b0;
        run_frame("f5", {GA, GA, GA, GA}, 4'b0000, 6, 16'h3333, 15, 16'h5555);
        run_frame("f6", {G5, G5, G5, G5}, 4'b0000, -1, 16'h0, -1, 16'h0);
        // Stale pending 0x3333 must not resurface; queue blink/dp/blank attributes.
        bus.blink_i = 4'b0001;
        bus.dp_i    = 4'b0010;
        bus.blank_i = 4'b0100;
        run_frame("f7", {G5, G5, G5, G5}, 4'b0000, 0, 16'h000F, -1, 16'h0);
        // Blink phase is 1 in frames 8, 11, 12 and 0 in frames 9, 10.
        run_frame("f8",  {G0, OFF, G0, OFF}, 4'b0010, -1, 16'h0, -1, 16'h0);
        run_frame("f9",  {G0, OFF, G0, GF},  4'b0010, -1, 16'h0, -1, 16'h0);
        run_frame("f10", {G0, OFF, G0, GF},  4'b0010, -1, 16'h0, -1, 16'h0);
        run_frame("f11", {G0, OFF, G0, OFF}, 4'b0010, -1, 16'h0, -1, 16'h0);
        run_frame("f12", {G0, OFF, G0, OFF}, 4'b0010, -1, 16'h0, -1, 16'h0);

        // Frame 13 (blink phase 0): scan into digit 1, then drop enable mid-slot.
        cyc("en.a0", 4'b1111, ~GF, 1'b1, 1'b0);
        cyc("en.a1", 4'b1110, ~GF, 1'b1, 1'b0);
        cyc("en.a2", 4'b1110, ~GF, 1'b1, 1'b0);
        cyc("en.a3", 4'b1110, ~GF, 1'b1, 1'b0);
        cyc("en.a4", 4'b1111, ~G0, 1'b0, 1'b0);
        cyc("en.a5", 4'b1101, ~G0, 1'b0, 1'b0);
        bus.en_i = 1'b0;
        cyc("en.off0", 4'b1111, 7'h7F, 1'b1, 1'b0);
        cyc("en.off1", 4'b1111, 7'h7F, 1'b1, 1'b0);
        cyc("en.off2", 4'b1111, 7'h7F, 1'b1, 1'b0);
        // Resume exactly where it stopped: slot 2 of digit 1.
        bus.en_i = 1'b1;
        cyc("en.b0", 4'b1101, ~G0, 1'b0, 1'b0);
        cyc("en.b1", 4'b1101, ~G0, 1'b0, 1'b0);
        cyc("en.b2", 4'b1111, ~OFF, 1'b1, 1'b0);
        cyc("en.b3", 4'b1011, ~OFF, 1'b1, 1'b0);

        // Asynchronous reset between edges: pins go off before the next clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.an",    32'(bus.an_o),    32'h0000000F);
        chk("arst.seg",   32'(bus.seg_o),   32'h0000007F);
        chk("arst.dp",    32'(bus.dp_o),    32'h00000001);
        chk("arst.frame", 32'(bus.frame_o), 32'h00000000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Scanning restarts at digit 0 with the cleared active value.
        cyc("rel.0", 4'b1111, ~G0, 1'b1, 1'b0);
        cyc("rel.1", 4'b1110, ~G0, 1'b1, 1'b0);
        cyc("rel.2", 4'b1110, ~G0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
